// File: rtl/masked_subword.sv
// Serial masked SubWord: four masked bytes pass one at a time through a shared masked S-box.
// Each output byte is re-masked with a fresh LFSR byte, and that byte is returned as out_mask.
module masked_subword #(
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_mask,
  input  logic        in_enc,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_mask
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [31:0] data_q;
  logic [31:0] mask_q;
  logic        enc_q;
  logic [15:0] lfsr_q;
  logic [31:0] out_data_q;
  logic [31:0] out_mask_q;

  logic        accept;
  logic        seed_ok;
  logic [15:0] seed_val;
  logic [15:0] lfsr_next;
  logic [7:0]  sb_a;
  logic [7:0]  sb_m;
  logic [7:0]  sb_out;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned k);
    logic [15:0] t;
    t = {x, x} << k;
    return t[15:8];
  endfunction

  // Masked S-box: the unmasked byte exists only inside this combinational cone.
  function automatic logic [7:0] b_sbox(input logic [7:0] a, input logic [7:0] m,
                                        input logic [7:0] n, input logic enc);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] t;
    x = a ^ m;
    if (enc) begin
      t = gf_inv(x);
      y = t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    end else begin
      t = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
      y = gf_inv(t);
    end
    return y ^ n;
  endfunction

  function automatic logic [15:0] lfsr_step8(input logic [15:0] l);
    logic [15:0] v;
    v = l;
    for (int i = 0; i < 8; i++) begin
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    end
    return v;
  endfunction

  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    accept    = in_valid && in_ready;
    // An accept takes priority over a seed load; RUN never reseeds.
    seed_ok   = seed_load && !accept && (state_q != StRun);
    seed_val  = (seed == 16'h0000) ? LFSR_INIT : seed;
    lfsr_next = lfsr_step8(lfsr_q);
    sb_a      = data_q[{idx_q, 3'b000} +: 8];
    sb_m      = mask_q[{idx_q, 3'b000} +: 8];
    sb_out    = b_sbox(sb_a, sb_m, lfsr_q[7:0], enc_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      data_q     <= 32'h0;
      mask_q     <= 32'h0;
      enc_q      <= 1'b0;
      lfsr_q     <= LFSR_INIT;
      out_data_q <= 32'h0;
      out_mask_q <= 32'h0;
    end else begin
      if (seed_ok) lfsr_q <= seed_val;
      if (accept) begin
        data_q  <= in_data;
        mask_q  <= in_mask;
        enc_q   <= in_enc;
        idx_q   <= 2'd0;
        state_q <= StRun;
      end else begin
        case (state_q)
          StRun: begin
            out_data_q[{idx_q, 3'b000} +: 8] <= sb_out;
            out_mask_q[{idx_q, 3'b000} +: 8] <= lfsr_q[7:0];
            lfsr_q <= lfsr_next;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) state_q <= StDone;
          end
          StDone: begin
            if (out_ready) state_q <= StIdle;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;

endmodule

// File: tb/tb_masked_subword.sv
// Bench for masked_subword: driver pushes expected S(X) and mask per accepted word,
// a monitor pops and compares on each output handshake.
module tb_masked_subword;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_mask;
  logic        in_enc;
  logic        seed_load;
  logic [15:0] seed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_mask;

  masked_subword #(.LFSR_INIT(16'hACE1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_enc    (in_enc),
    .seed_load (seed_load),
    .seed      (seed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask)
  );

  always #5 CLK = ~CLK;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] lfsr_m;
  logic [31:0] exp_s_q[$];
  logic [31:0] exp_m_q[$];
  logic [7:0]  fwd_tab[256];
  logic [7:0]  inv_tab[256];
  logic [2047:0] sb_flat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step8(input logic [15:0] l);
    logic [15:0] v;
    v = l;
    for (int i = 0; i < 8; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] x, input logic enc);
    logic [31:0] s;
    for (int b = 0; b < 4; b++) s[8*b +: 8] = enc ? fwd_tab[x[8*b +: 8]] : inv_tab[x[8*b +: 8]];
    return s;
  endfunction

  // Monitor: compare whenever the output handshake will complete at the next edge.
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      if (exp_s_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        check("out_sx", out_data ^ out_mask, exp_s_q.pop_front());
        check("out_mask", out_mask, exp_m_q.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] m, input logic enc,
                      output int waited);
    logic [31:0] mk;
    in_valid = 1'b1;
    in_data  = x ^ m;
    in_mask  = m;
    in_enc   = enc;
    waited   = 0;
    @(negedge CLK);
    while (!in_ready && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      for (int b = 0; b < 4; b++) begin
        mk[8*b +: 8] = lfsr_m[7:0];
        lfsr_m = step8(lfsr_m);
      end
      exp_s_q.push_back(exp_word(x, enc));
      exp_m_q.push_back(mk);
    end
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int w;
    w = 0;
    @(negedge CLK);
    while (!out_valid && w < 30) begin
      @(negedge CLK);
      w++;
    end
    if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_s_q.size() != 0 && w < 100) begin
      @(negedge CLK);
      w++;
    end
    if (exp_s_q.size() != 0) begin
      check("drain_timeout", exp_s_q.size(), 32'd0);
      exp_s_q.delete();
      exp_m_q.delete();
    end
    sync();
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed      = s;
    seed_load = 1'b1;
    sync();
    seed_load = 1'b0;
    lfsr_m    = (s == 16'h0) ? 16'hACE1 : s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          j;
    logic [31:0] cap_d;
    logic [31:0] cap_m;
    logic [31:0] x;

    sb_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) fwd_tab[i] = sb_flat[2047 - 8*i -: 8];
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = i[7:0];

    RST = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_enc = 1'b0;
    seed_load = 1'b0; seed = '0; out_ready = 1'b1;
    lfsr_m = 16'hACE1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    @(negedge CLK);
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_mask", out_mask, 32'd0);
    sync();

    // Forward, zero mask, with latency check.
    send(32'h03020100, 32'h0, 1'b1, w);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("lat_edge3", out_valid, 32'd0);
    @(negedge CLK);
    check("lat_edge4", out_valid, 32'd1);
    check("fwd_sx", out_data ^ out_mask, 32'h7B777C63);
    check("first_mask", out_mask[7:0], 32'hE1);
    wait_drain();

    // Inverse with a mask.
    send(32'h03020100, 32'h5A3CC396, 1'b0, w);
    wait_out_valid();
    check("inv_sx", out_data ^ out_mask, 32'hD56A0952);
    wait_drain();

    // Backpressure hold, then back-to-back accept on the output handshake.
    out_ready = 1'b0;
    send(32'h0c0d0e0f, 32'h11223344, 1'b1, w);
    wait_out_valid();
    cap_d = out_data;
    cap_m = out_mask;
    repeat (10) begin
      @(negedge CLK);
      check("hold_valid", out_valid, 32'd1);
      check("hold_data", out_data, cap_d);
      check("hold_mask", out_mask, cap_m);
    end
    sync();
    out_ready = 1'b1;
    send(32'hdeadbeef, 32'h0f0f0f0f, 1'b0, w);
    check("b2b_same_cycle", w, 32'd0);
    wait_drain();

    // Bulk: every byte value in both directions, back-to-back.
    for (int i = 0; i < 256; i++) begin
      j = i >> 1;
      x = {8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1), 8'(4*j)};
      send(x, $urandom, i[0], w);
    end
    wait_drain();

    // Seed zero falls back to the reset value.
    do_seed(16'h0000);
    send(32'h44332211, 32'h99887766, 1'b1, w);
    wait_out_valid();
    check("seed0_mask", out_mask[7:0], 32'hE1);
    wait_drain();

    do_seed(16'h1234);
    send(32'h00112233, 32'h0a0b0c0d, 1'b0, w);
    wait_out_valid();
    check("seed1234_mask", out_mask[7:0], 32'h34);
    wait_drain();

    // Seed load during RUN is ignored.
    send(32'h55aa55aa, 32'h12345678, 1'b1, w);
    seed = 16'h5555;
    seed_load = 1'b1;
    repeat (3) @(posedge CLK);
    #1 seed_load = 1'b0;
    wait_drain();
    send(32'hcafef00d, 32'h87654321, 1'b0, w);
    wait_drain();

    // Seed load coincident with an accept is ignored.
    seed = 16'h5555;
    seed_load = 1'b1;
    send(32'h01234567, 32'h76543210, 1'b1, w);
    seed_load = 1'b0;
    wait_drain();
    send(32'h89abcdef, 32'hfedcba98, 1'b1, w);
    wait_drain();

    // Reset two edges after an accept discards the word.
    send(32'h10203040, 32'h0badf00d, 1'b1, w);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    void'(exp_s_q.pop_back());
    void'(exp_m_q.pop_back());
    lfsr_m = 16'hACE1;
    repeat (3) begin
      @(negedge CLK);
      check("rst_mid_valid", out_valid, 32'd0);
    end
    check("rst_mid_data", out_data, 32'd0);
    sync();
    RST = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      check("post_rst_valid", out_valid, 32'd0);
    end
    check("post_rst_ready", in_ready, 32'd1);
    sync();
    send(32'h03020100, 32'h0, 1'b1, w);
    wait_out_valid();
    check("post_rst_sx", out_data ^ out_mask, 32'h7B777C63);
    wait_drain();

    check("sb_empty", exp_s_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
